apb_arb_master: RTL and testbench

Two-requester APB master that shares the single APB slave port (the 64-entry byte memory slave) between two on-chip requesters. It arbitrates round-robin and sequences each transfer through the APB IDLE/SETUP/ACCESS phases. It returns read data and a completion pulse to the winning requester, and aborts a transfer whose slave never asserts pready.

---
 rtl/apb_arb_master_if.sv | 24 ++
 rtl/apb_arb_master.sv | 124 ++++++++++++
 tb/tb_apb_arb_master.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_master_if.sv
// APB bus between the arbitrating master and the shared slave port.
// The master drives select/enable/address/data; the slave returns data and ready.
interface apb_arb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester round-robin APB master with IDLE/SETUP/ACCESS sequencing.
// A transfer whose slave never asserts pready is aborted with err.
module apb_arb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic [1:0]          req,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  apb_arb_master_if.master    apb
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        last;
  logic        gnt;
  logic        sel;
  logic        any;
  logic [1:0]  elig;
  logic [CW-1:0] cnt;
  logic        expire;
  logic        finish;

  // done is only ever high in the IDLE cycle after a completion,
  // so it masks the just-served requester for exactly that cycle.
  assign elig   = req & ~done;
  assign any    = |elig;
  assign expire = (cnt == CW'(TIMEOUT - 1));
  assign finish = (state == ACCESS) && (apb.pready || expire);

  always_comb begin
    sel = 1'b0;
    if (elig == 2'b11)
      sel = ~last;
    else
      sel = elig[1];
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (finish) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last        <= 1'b1;
      gnt         <= 1'b0;
      cnt         <= '0;
      done        <= 2'b00;
      err         <= 1'b0;
      rdata       <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            apb.psel   <= 1'b1;
            apb.pwrite <= req_write[sel];
            apb.paddr  <= sel ? req_addr[2*ADDR_W-1:ADDR_W]
                              : req_addr[ADDR_W-1:0];
            apb.pwdata <= sel ? req_wdata[2*DATA_W-1:DATA_W]
                              : req_wdata[DATA_W-1:0];
            last       <= sel;
            gnt        <= sel;
          end
        end
        SETUP: begin
          apb.penable <= 1'b1;
          cnt         <= '0;
        end
        ACCESS: begin
          if (finish) begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            done        <= gnt ? 2'b10 : 2'b01;
            cnt         <= '0;
            if (apb.pready) begin
              if (!apb.pwrite) rdata <= apb.prdata;
            end else begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: write, read-back, contention,
// wait states, timeout abort and reset in the middle of ACCESS.
module tb_apb_arb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  req;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rdata;

  int total = 0;
  int bad   = 0;

  apb_arb_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_arb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .apb       (bus.master)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    presetn     = 1'b0;
    req         = 2'b00;
    req_write   = 2'b00;
    req_addr    = 16'h0000;
    req_wdata   = 16'h0000;
    bus.prdata  = 8'h00;
    bus.pready  = 1'b1;
    #12;
    chk("rst_psel", 32'(bus.psel), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_pwrite", 32'(bus.pwrite), 0);
    chk("rst_paddr", 32'(bus.paddr), 0);
    chk("rst_pwdata", 32'(bus.pwdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    presetn = 1'b1;
    tick();

    // single write from requester 0
    req       = 2'b01;
    req_write = 2'b01;
    req_addr  = 16'h0005;
    req_wdata = 16'h00A5;
    tick();
    chk("wr_psel1", 32'(bus.psel), 1);
    chk("wr_pen1", 32'(bus.penable), 0);
    chk("wr_paddr1", 32'(bus.paddr), 32'h05);
    chk("wr_pwdata1", 32'(bus.pwdata), 32'hA5);
    chk("wr_pwrite1", 32'(bus.pwrite), 1);
    tick();
    chk("wr_pen2", 32'(bus.penable), 1);
    chk("wr_paddr2", 32'(bus.paddr), 32'h05);
    chk("wr_done2", 32'(done), 0);
    tick();
    chk("wr_done3", 32'(done), 32'h1);
    chk("wr_err3", 32'(err), 0);
    chk("wr_psel3", 32'(bus.psel), 0);
    chk("wr_pwdata3", 32'(bus.pwdata), 32'hA5);
    req = 2'b00;
    tick();
    chk("wr_done4", 32'(done), 0);

    // read-back from requester 1
    req        = 2'b10;
    req_write  = 2'b00;
    req_addr   = 16'h0500;
    bus.prdata = 8'hA5;
    tick();
    chk("rd_psel1", 32'(bus.psel), 1);
    chk("rd_pwrite1", 32'(bus.pwrite), 0);
    chk("rd_paddr1", 32'(bus.paddr), 32'h05);
    tick();
    chk("rd_pen2", 32'(bus.penable), 1);
    tick();
    chk("rd_done3", 32'(done), 32'h2);
    chk("rd_rdata3", 32'(rdata), 32'hA5);
    req        = 2'b00;
    bus.prdata = 8'h11;
    tick();
    chk("rd_hold", 32'(rdata), 32'hA5);
    chk("rd_done4", 32'(done), 0);

    // contention: both requesting continuously after reset
    presetn = 1'b0;
    tick();
    presetn   = 1'b1;
    req       = 2'b11;
    req_write = 2'b11;
    req_addr  = 16'h2010;
    req_wdata = 16'hBBAA;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ct_psel", 32'(bus.psel), 1);
      chk("ct_paddr", 32'(bus.paddr), (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
      chk("ct_pen", 32'(bus.penable), 1);
      tick();
      chk("ct_done", 32'(done), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("ct_err", 32'(err), 0);
    end
    req = 2'b00;
    tick();

    // wait states: pready low for three ACCESS cycles
    req        = 2'b01;
    req_write  = 2'b00;
    req_addr   = 16'h0033;
    bus.pready = 1'b0;
    bus.prdata = 8'h5C;
    tick();
    chk("ws_psel", 32'(bus.psel), 1);
    tick();
    chk("ws_pen0", 32'(bus.penable), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ws_pen", 32'(bus.penable), 1);
      chk("ws_done", 32'(done), 0);
    end
    bus.pready = 1'b1;
    tick();
    chk("ws_done_end", 32'(done), 32'h1);
    chk("ws_err_end", 32'(err), 0);
    chk("ws_rdata", 32'(rdata), 32'h5C);
    chk("ws_pen_end", 32'(bus.penable), 0);
    req = 2'b00;
    tick();

    // timeout: slave never ready
    req        = 2'b10;
    req_write  = 2'b00;
    req_addr   = 16'h4400;
    bus.pready = 1'b0;
    bus.prdata = 8'hEE;
    tick();
    chk("to_psel", 32'(bus.psel), 1);
    tick();
    chk("to_pen0", 32'(bus.penable), 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("to_wait", {30'd0, bus.penable, bus.psel}, 32'h3);
      chk("to_nodone", {29'd0, err, done}, 0);
    end
    tick();
    chk("to_done", 32'(done), 32'h2);
    chk("to_err", 32'(err), 1);
    chk("to_psel_drop", 32'(bus.psel), 0);
    chk("to_pen_drop", 32'(bus.penable), 0);
    chk("to_rdata", 32'(rdata), 32'h5C);
    req = 2'b00;
    tick();
    chk("to_err_clr", 32'(err), 0);
    chk("to_done_clr", 32'(done), 0);

    // reset in the middle of ACCESS
    bus.pready = 1'b0;
    req        = 2'b10;
    req_write  = 2'b10;
    req_addr   = 16'h0907;
    req_wdata  = 16'h0102;
    tick();
    tick();
    chk("mr_pen", 32'(bus.penable), 1);
    presetn = 1'b0;
    #1;
    chk("mr_psel", 32'(bus.psel), 0);
    chk("mr_pen0", 32'(bus.penable), 0);
    chk("mr_done", 32'(done), 0);
    bus.pready = 1'b1;
    tick();
    chk("mr_done2", 32'(done), 0);
    presetn = 1'b1;
    req     = 2'b11;
    tick();
    chk("mr_gnt_psel", 32'(bus.psel), 1);
    chk("mr_gnt_addr", 32'(bus.paddr), 32'h07);
    tick();
    tick();
    chk("mr_gnt_done", 32'(done), 32'h1);
    req = 2'b00;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
